unidade_controle_desafio: RTL and testbench

Moore FSM that sequences the memory-game datapath (`fluxo_dados_desafio`). It drives that datapath's counter, register and timeout control inputs, and consumes its status outputs `jogadaIgualMemoria`, `enderecoIgualSequencia`, `tem_jogada`, `fimS` and `db_timeout`. It runs growing rounds: round k requires plays 0..k, for k = 0..15. It ends in one of three states: win, wrong play or timeout. A 4-bit state code is exported for hex-display debug.

---
 rtl/unidade_controle_desafio.sv | 133 +++++++++++++
 tb/tb_unidade_controle_desafio.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_desafio.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_desafio
// Description : Moore control FSM for the memory-game datapath. It runs
//               growing rounds (round k checks plays 0..k) and stops in a
//               win, wrong-play or timeout state. The state code is exported
//               for hex-display debug.
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_desafio (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogadaIgualMemoria,
  input  logic       enderecoIgualSequencia,
  input  logic       tem_jogada,
  input  logic       fimS,
  input  logic       db_timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraS,
  output logic       contaS,
  output logic       zeraR,
  output logic       registraR,
  output logic       estado_espera,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  // State codes double as the debug display value, so they are fixed.
  localparam logic [3:0] c_inicial           = 4'h0;
  localparam logic [3:0] c_preparacao        = 4'h1;
  localparam logic [3:0] c_inicia_rodada     = 4'h2;
  localparam logic [3:0] c_espera            = 4'h3;
  localparam logic [3:0] c_registra          = 4'h4;
  localparam logic [3:0] c_comparacao        = 4'h5;
  localparam logic [3:0] c_proxima_jogada    = 4'h6;
  localparam logic [3:0] c_proxima_sequencia = 4'h7;
  localparam logic [3:0] c_fim_acertou       = 4'hA;
  localparam logic [3:0] c_fim_timeout       = 4'hB;
  localparam logic [3:0] c_fim_errou         = 4'hE;

  logic [3:0] r_estado;
  logic [3:0] w_proximo;

  // State register; reset overrides every transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= c_inicial;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // Next-state logic; unused codes fall back to the idle state.
  always_comb begin
    w_proximo = c_inicial;
    case (r_estado)
      c_inicial:           w_proximo = iniciar ? c_preparacao : c_inicial;
      c_preparacao:        w_proximo = c_inicia_rodada;
      c_inicia_rodada:     w_proximo = c_espera;
      c_espera: begin
        // Timeout beats a play arriving in the same cycle.
        if (db_timeout)      w_proximo = c_fim_timeout;
        else if (tem_jogada) w_proximo = c_registra;
        else                 w_proximo = c_espera;
      end
      c_registra:          w_proximo = c_comparacao;
      c_comparacao: begin
        if (!jogadaIgualMemoria)          w_proximo = c_fim_errou;
        else if (!enderecoIgualSequencia) w_proximo = c_proxima_jogada;
        else if (fimS)                    w_proximo = c_fim_acertou;
        else                              w_proximo = c_proxima_sequencia;
      end
      c_proxima_jogada:    w_proximo = c_espera;
      c_proxima_sequencia: w_proximo = c_inicia_rodada;
      c_fim_acertou:       w_proximo = iniciar ? c_preparacao : c_fim_acertou;
      c_fim_errou:         w_proximo = iniciar ? c_preparacao : c_fim_errou;
      c_fim_timeout:       w_proximo = iniciar ? c_preparacao : c_fim_timeout;
      default:             w_proximo = c_inicial;
    endcase
  end

  // Moore output decode from the current state only.
  always_comb begin
    zeraE         = 1'b0;
    contaE        = 1'b0;
    zeraS         = 1'b0;
    contaS        = 1'b0;
    zeraR         = 1'b0;
    registraR     = 1'b0;
    estado_espera = 1'b0;
    pronto        = 1'b0;
    acertou       = 1'b0;
    errou         = 1'b0;
    timeout       = 1'b0;
    db_estado     = r_estado;
    case (r_estado)
      c_preparacao: begin
        zeraE = 1'b1;
        zeraS = 1'b1;
        zeraR = 1'b1;
      end
      c_inicia_rodada: begin
        zeraE = 1'b1;
        zeraR = 1'b1;
      end
      c_espera:            estado_espera = 1'b1;
      c_registra:          registraR     = 1'b1;
      c_proxima_jogada:    contaE        = 1'b1;
      c_proxima_sequencia: contaS        = 1'b1;
      c_fim_acertou: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      c_fim_errou: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      c_fim_timeout: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_desafio.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle_desafio
// Description : Self-checking bench for unidade_controle_desafio: directed
//               vector table for the game scenarios, then random stimulus
//               against a behavioural game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_desafio;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       jogadaIgualMemoria = 1'b0;
  logic       enderecoIgualSequencia = 1'b0;
  logic       tem_jogada = 1'b0;
  logic       fimS = 1'b0;
  logic       db_timeout = 1'b0;
  logic       zeraE, contaE, zeraS, contaS, zeraR, registraR;
  logic       estado_espera, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int tests = 0;
  int fails = 0;

  unidade_controle_desafio dut (
    .clock                  (clock),
    .reset                  (reset),
    .iniciar                (iniciar),
    .jogadaIgualMemoria     (jogadaIgualMemoria),
    .enderecoIgualSequencia (enderecoIgualSequencia),
    .tem_jogada             (tem_jogada),
    .fimS                   (fimS),
    .db_timeout             (db_timeout),
    .zeraE                  (zeraE),
    .contaE                 (contaE),
    .zeraS                  (zeraS),
    .contaS                 (contaS),
    .zeraR                  (zeraR),
    .registraR              (registraR),
    .estado_espera          (estado_espera),
    .pronto                 (pronto),
    .acertou                (acertou),
    .errou                  (errou),
    .timeout                (timeout),
    .db_estado              (db_estado)
  );

  always #5 clock = ~clock;

  // Stimulus bit order: {reset, iniciar, jogadaIgualMemoria,
  //                      enderecoIgualSequencia, tem_jogada, fimS, db_timeout}
  typedef struct {
    logic [6:0] stim;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Output masks in {zeraE, contaE, zeraS, contaS, zeraR, registraR,
  //                  estado_espera, pronto, acertou, errou, timeout} order.
  localparam logic [10:0] c_ZE = 11'h400, c_CE = 11'h200, c_ZS = 11'h100,
                          c_CS = 11'h080, c_ZR = 11'h040, c_RR = 11'h020,
                          c_EE = 11'h010, c_PR = 11'h008, c_AC = 11'h004,
                          c_ER = 11'h002, c_TO = 11'h001;

  logic [10:0] got_outs;
  assign got_outs = {zeraE, contaE, zeraS, contaS, zeraR, registraR,
                     estado_espera, pronto, acertou, errou, timeout};

  // What each game phase asks of the datapath.
  function automatic logic [10:0] exp_outs(input logic [3:0] s);
    logic [10:0] o;
    o = 11'h000;
    if (s == 4'h1) o = c_ZE | c_ZS | c_ZR;
    if (s == 4'h2) o = c_ZE | c_ZR;
    if (s == 4'h3) o = c_EE;
    if (s == 4'h4) o = c_RR;
    if (s == 4'h6) o = c_CE;
    if (s == 4'h7) o = c_CS;
    if (s == 4'hA) o = c_PR | c_AC;
    if (s == 4'hE) o = c_PR | c_ER;
    if (s == 4'hB) o = c_PR | c_ER | c_TO;
    return o;
  endfunction

  // Game-level model: given the current phase and the inputs seen this cycle,
  // where does the game go next.
  function automatic logic [3:0] model_next(input logic [3:0] s, input logic [6:0] st);
    logic rst, ini, jim, eis, tj, fim, tout;
    logic game_over;
    {rst, ini, jim, eis, tj, fim, tout} = st;
    game_over = (s == 4'hA) || (s == 4'hB) || (s == 4'hE);
    if (rst) return 4'h0;
    if (s == 4'h0 || game_over) return ini ? 4'h1 : s;
    if (s == 4'h1 || s == 4'h7) return 4'h2;
    if (s == 4'h2 || s == 4'h6) return 4'h3;
    if (s == 4'h3) return tout ? 4'hB : (tj ? 4'h4 : 4'h3);
    if (s == 4'h4) return 4'h5;
    if (s == 4'h5) begin
      if (!jim) return 4'hE;
      if (!eis) return 4'h6;
      return fim ? 4'hA : 4'h7;
    end
    return 4'h0;
  endfunction

  function automatic vec_t mk(input logic [6:0] stim, input logic [3:0] exp);
    vec_t v;
    v.stim = stim;
    v.exp  = exp;
    return v;
  endfunction

  task automatic apply(input logic [6:0] st);
    @(negedge clock);
    {reset, iniciar, jogadaIgualMemoria, enderecoIgualSequencia,
     tem_jogada, fimS, db_timeout} = st;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] es);
    tests++;
    if (db_estado !== es) begin
      fails++;
      $display("FAIL %s[%0d] db_estado: got %h expected %h", name, idx, db_estado, es);
    end
    tests++;
    if (got_outs !== exp_outs(es)) begin
      fails++;
      $display("FAIL %s[%0d] outputs (state %h): got %b expected %b",
               name, idx, es, got_outs, exp_outs(es));
    end
  endtask

  logic [3:0] m;
  logic [6:0] st;

  initial begin
    // Reset sequencing and start
    vecs.push_back(mk(7'b1000000, 4'h0));
    vecs.push_back(mk(7'b1000000, 4'h0));
    vecs.push_back(mk(7'b0000000, 4'h0));
    vecs.push_back(mk(7'b0100000, 4'h1));
    vecs.push_back(mk(7'b0000000, 4'h2));
    vecs.push_back(mk(7'b0000000, 4'h3));
    // Round 0 correct: 3->4->5->7->2->3
    vecs.push_back(mk(7'b0011100, 4'h4));
    vecs.push_back(mk(7'b0011000, 4'h5));
    vecs.push_back(mk(7'b0011000, 4'h7));
    vecs.push_back(mk(7'b0000000, 4'h2));
    vecs.push_back(mk(7'b0000000, 4'h3));
    // Mid-round play, idle wait, then wrong play
    vecs.push_back(mk(7'b0000100, 4'h4));
    vecs.push_back(mk(7'b0000000, 4'h5));
    vecs.push_back(mk(7'b0010000, 4'h6));
    vecs.push_back(mk(7'b0000000, 4'h3));
    vecs.push_back(mk(7'b0000000, 4'h3));
    vecs.push_back(mk(7'b0000100, 4'h4));
    vecs.push_back(mk(7'b0000000, 4'h5));
    vecs.push_back(mk(7'b0001010, 4'hE));
    vecs.push_back(mk(7'b0000100, 4'hE));
    vecs.push_back(mk(7'b0100000, 4'h1));
    vecs.push_back(mk(7'b0100000, 4'h2));   // iniciar ignored mid-game
    vecs.push_back(mk(7'b0000000, 4'h3));
    // Full win, hold, restart
    vecs.push_back(mk(7'b0000100, 4'h4));
    vecs.push_back(mk(7'b0000000, 4'h5));
    vecs.push_back(mk(7'b0011010, 4'hA));
    vecs.push_back(mk(7'b0000000, 4'hA));
    vecs.push_back(mk(7'b0100000, 4'h1));
    vecs.push_back(mk(7'b0000000, 4'h2));
    vecs.push_back(mk(7'b0000000, 4'h3));
    // Timeout beats a simultaneous play
    vecs.push_back(mk(7'b0011101, 4'hB));
    vecs.push_back(mk(7'b0000100, 4'hB));
    vecs.push_back(mk(7'b0100000, 4'h1));
    vecs.push_back(mk(7'b0000000, 4'h2));
    vecs.push_back(mk(7'b0000001, 4'h3));   // timeout outside espera ignored
    // Reset in comparacao, then plays in idle are dropped
    vecs.push_back(mk(7'b0000100, 4'h4));
    vecs.push_back(mk(7'b0000000, 4'h5));
    vecs.push_back(mk(7'b1010000, 4'h0));
    vecs.push_back(mk(7'b0000100, 4'h0));
    vecs.push_back(mk(7'b0011111, 4'h0));

    foreach (vecs[i]) begin
      apply(vecs[i].stim);
      check("vec", i, vecs[i].exp);
    end

    // Reset while in proxima_jogada
    apply(7'b0100000); check("rst6", 0, 4'h1);
    apply(7'b0000000); check("rst6", 1, 4'h2);
    apply(7'b0000000); check("rst6", 2, 4'h3);
    apply(7'b0000100); check("rst6", 3, 4'h4);
    apply(7'b0000000); check("rst6", 4, 4'h5);
    apply(7'b0010000); check("rst6", 5, 4'h6);
    apply(7'b1000000); check("rst6", 6, 4'h0);

    // Random play against the game model
    m = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      st[6] = ($urandom_range(0, 59) == 0);
      st[5] = ($urandom_range(0, 3) == 0);
      st[4] = ($urandom_range(0, 7) != 0);
      st[3] = ($urandom_range(0, 1) == 0);
      st[2] = ($urandom_range(0, 2) == 0);
      st[1] = ($urandom_range(0, 3) == 0);
      st[0] = ($urandom_range(0, 11) == 0);
      apply(st);
      m = model_next(m, st);
      check("rand", n, m);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
